// File: rtl/kf6845_bus_master.sv
// Host-side initiator: turns a valid/ready register request into the KF6845 two-phase bus sequence.
// Define KF6845_ADDR_CACHE_EN to skip the address phase when the CRTC address register already holds req_addr.
module kf6845_bus_master #(
  parameter int ENABLE_CYCLES = 1,
  parameter int GAP_CYCLES    = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_write,
  input  logic [4:0] req_addr,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  output logic       rsp_error,
  output logic [7:0] rsp_rdata,
  output logic       CS_N,
  output logic       RS,
  output logic       ENABLE,
  output logic       R_OR_W,
  output logic [7:0] D_OUT,
  input  logic [7:0] D_IN
);

  typedef enum logic [2:0] {IDLE, ADDR_EN, ADDR_GAP, DATA_EN, DATA_GAP, ERR_RSP} state_t;

  localparam logic [7:0] EN_LAST  = 8'(ENABLE_CYCLES - 1);
  localparam logic [7:0] GAP_LAST = 8'(GAP_CYCLES - 1);

  state_t     state, state_nxt;
  logic [7:0] cnt, cnt_nxt;
  logic       wr_q;
  logic [4:0] addr_q;
  logic [7:0] wdata_q, rd_q;
  logic       accept, legal, cache_hit;
  logic       cur_write;
  logic [4:0] cur_addr;
  logic [7:0] cur_wdata;
  logic       cs_n_nxt, rs_nxt, en_nxt, rw_nxt, ready_nxt, rsp_valid_nxt, rsp_error_nxt;
  logic [7:0] dout_nxt, rsp_rdata_nxt;

  assign accept = req_valid & req_ready;
  assign legal  = req_write ? (req_addr <= 5'd17) : (req_addr >= 5'd14 && req_addr <= 5'd17);

`ifdef KF6845_ADDR_CACHE_EN
  logic [4:0] cache_addr;
  logic       cache_vld;

  // Mirrors the CRTC address register as of the last completed address phase.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cache_addr <= 5'd0;
      cache_vld  <= 1'b0;
    end else if (state == ADDR_EN && cnt == 8'd0) begin
      cache_addr <= addr_q;
      cache_vld  <= 1'b1;
    end
  end

  assign cache_hit = cache_vld && (cache_addr == req_addr);
`else
  assign cache_hit = 1'b0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= 8'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          if (!legal) begin
            state_nxt = ERR_RSP;
          end else begin
            cnt_nxt   = EN_LAST;
            state_nxt = cache_hit ? DATA_EN : ADDR_EN;
          end
        end
      end
      ADDR_EN: begin
        if (cnt == 8'd0) begin
          state_nxt = ADDR_GAP;
          cnt_nxt   = GAP_LAST;
        end else cnt_nxt = cnt - 8'd1;
      end
      ADDR_GAP: begin
        if (cnt == 8'd0) begin
          state_nxt = DATA_EN;
          cnt_nxt   = EN_LAST;
        end else cnt_nxt = cnt - 8'd1;
      end
      DATA_EN: begin
        if (cnt == 8'd0) begin
          state_nxt = DATA_GAP;
          cnt_nxt   = GAP_LAST;
        end else cnt_nxt = cnt - 8'd1;
      end
      DATA_GAP: begin
        if (cnt == 8'd0) state_nxt = IDLE;
        else cnt_nxt = cnt - 8'd1;
      end
      ERR_RSP: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are registered from the next state, so the request fields are
  // taken straight from the inputs on the accepting edge.
  always_comb begin
    cur_write     = accept ? req_write : wr_q;
    cur_addr      = accept ? req_addr  : addr_q;
    cur_wdata     = accept ? req_wdata : wdata_q;
    cs_n_nxt      = 1'b1;
    rs_nxt        = 1'b1;
    en_nxt        = 1'b0;
    rw_nxt        = 1'b1;
    dout_nxt      = 8'hFF;
    ready_nxt     = (state_nxt == IDLE);
    rsp_valid_nxt = 1'b0;
    rsp_error_nxt = rsp_error;
    rsp_rdata_nxt = rsp_rdata;
    case (state_nxt)
      ADDR_EN: begin
        cs_n_nxt = 1'b0;
        rs_nxt   = 1'b0;
        en_nxt   = 1'b1;
        rw_nxt   = 1'b0;
        dout_nxt = {3'b000, cur_addr};
      end
      DATA_EN: begin
        cs_n_nxt = 1'b0;
        en_nxt   = 1'b1;
        rw_nxt   = ~cur_write;
        dout_nxt = cur_write ? cur_wdata : 8'hFF;
      end
      default: ;
    endcase
    if (state == DATA_GAP && cnt == 8'd0) begin
      rsp_valid_nxt = 1'b1;
      rsp_error_nxt = 1'b0;
      rsp_rdata_nxt = wr_q ? 8'h00 : rd_q;
    end
    if (state_nxt == ERR_RSP) begin
      rsp_valid_nxt = 1'b1;
      rsp_error_nxt = 1'b1;
      rsp_rdata_nxt = 8'h00;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_q      <= 1'b0;
      addr_q    <= 5'd0;
      wdata_q   <= 8'd0;
      rd_q      <= 8'd0;
      CS_N      <= 1'b1;
      RS        <= 1'b1;
      ENABLE    <= 1'b0;
      R_OR_W    <= 1'b1;
      D_OUT     <= 8'hFF;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_error <= 1'b0;
      rsp_rdata <= 8'h00;
    end else begin
      if (accept) begin
        wr_q    <= req_write;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
      if (state == DATA_EN && cnt == 8'd0) rd_q <= D_IN;
      CS_N      <= cs_n_nxt;
      RS        <= rs_nxt;
      ENABLE    <= en_nxt;
      R_OR_W    <= rw_nxt;
      D_OUT     <= dout_nxt;
      req_ready <= ready_nxt;
      rsp_valid <= rsp_valid_nxt;
      rsp_error <= rsp_error_nxt;
      rsp_rdata <= rsp_rdata_nxt;
    end
  end

endmodule

// File: tb/tb_kf6845_bus_master.sv
// Randomized bench for kf6845_bus_master: two instances (1/1 and 3/2 timing) checked cycle by cycle against an expected bus trace.
module tb_kf6845_bus_master;

`ifdef KF6845_ADDR_CACHE_EN
  localparam bit CACHE = 1'b1;
`else
  localparam bit CACHE = 1'b0;
`endif

  typedef struct packed {
    logic       cs_n;
    logic       rs;
    logic       en;
    logic       rw;
    logic [7:0] d;
    logic       rv;
    logic       rdy;
  } bus_t;

  logic       clock = 1'b0;
  logic       reset;
  logic       req_valid, req_write;
  logic [4:0] req_addr;
  logic [7:0] req_wdata, d_in;
  logic       sel;

  logic       rdy_a, rv_a, re_a, cs_a, rs_a, en_a, rw_a;
  logic [7:0] rd_a, do_a;
  logic       rdy_b, rv_b, re_b, cs_b, rs_b, en_b, rw_b;
  logic [7:0] rd_b, do_b;
  logic       val_a, val_b;

  int checks   = 0;
  int failures = 0;
  bit       cvld [2];
  logic [4:0] caddr [2];

  assign val_a = req_valid & ~sel;
  assign val_b = req_valid & sel;

  always #5 clock = ~clock;

  kf6845_bus_master dut_a (
    .clock(clock), .reset(reset), .req_valid(val_a), .req_ready(rdy_a), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rv_a), .rsp_error(re_a), .rsp_rdata(rd_a),
    .CS_N(cs_a), .RS(rs_a), .ENABLE(en_a), .R_OR_W(rw_a), .D_OUT(do_a), .D_IN(d_in)
  );

  kf6845_bus_master #(.ENABLE_CYCLES(3), .GAP_CYCLES(2)) dut_b (
    .clock(clock), .reset(reset), .req_valid(val_b), .req_ready(rdy_b), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rv_b), .rsp_error(re_b), .rsp_rdata(rd_b),
    .CS_N(cs_b), .RS(rs_b), .ENABLE(en_b), .R_OR_W(rw_b), .D_OUT(do_b), .D_IN(d_in)
  );

  bus_t       obs;
  logic       obs_err;
  logic [7:0] obs_rdata;
  assign obs       = sel ? {cs_b, rs_b, en_b, rw_b, do_b, rv_b, rdy_b} : {cs_a, rs_a, en_a, rw_a, do_a, rv_a, rdy_a};
  assign obs_err   = sel ? re_b : re_a;
  assign obs_rdata = sel ? rd_b : rd_a;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic bus_t mk(input logic cs_n, rs, en, rw, input logic [7:0] d, input logic rv, rdy);
    bus_t b;
    b = '{cs_n, rs, en, rw, d, rv, rdy};
    return b;
  endfunction

  task automatic idle_cycles(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clock);
      d_in = 8'($urandom);
      chk("idle", obs, mk(1, 1, 0, 1, 8'hFF, 0, 1));
    end
  endtask

  // Builds the expected per-cycle bus trace from the access rules, drives the
  // request and compares every cycle up to and including the response.
  task automatic access(input bit wr, input logic [4:0] a, input logic [7:0] wd, input logic [7:0] din,
                        input int abort_at);
    bus_t       tr[$];
    bus_t       idl;
    int         e, g;
    bit         legal, hit, bad;
    logic [7:0] exp_rd;
    e     = sel ? 3 : 1;
    g     = sel ? 2 : 1;
    idl   = mk(1, 1, 0, 1, 8'hFF, 0, 0);
    legal = wr ? (a <= 5'd17) : (a >= 5'd14 && a <= 5'd17);
    if (!legal) begin
      tr.push_back(mk(1, 1, 0, 1, 8'hFF, 1, 0));
      exp_rd = 8'h00;
    end else begin
      hit = CACHE && cvld[sel] && (caddr[sel] == a);
      if (!hit) begin
        repeat (e) tr.push_back(mk(0, 0, 1, 0, {3'b000, a}, 0, 0));
        repeat (g) tr.push_back(idl);
        cvld[sel]  = 1'b1;
        caddr[sel] = a;
      end
      repeat (e) tr.push_back(mk(0, 1, 1, ~wr, wr ? wd : 8'hFF, 0, 0));
      repeat (g) tr.push_back(idl);
      tr.push_back(mk(1, 1, 0, 1, 8'hFF, 1, 1));
      exp_rd = wr ? 8'h00 : din;
    end

    for (int k = 0; k < 8 && !obs.rdy; k++) @(negedge clock);
    chk("ready_before_req", obs.rdy, 1);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = a;
    req_wdata = wd;
    @(posedge clock);
    #1;
    req_valid = 1'b0;
    req_write = 1'($urandom);
    req_addr  = 5'($urandom);
    req_wdata = 8'($urandom);

    foreach (tr[i]) begin
      @(negedge clock);
      chk($sformatf("bus a%0d w%0d c%0d", a, wr, i + 1), obs, tr[i]);
      d_in = (tr[i].en && tr[i].rs) ? din : 8'($urandom);
      if (i + 1 == abort_at) begin
        #1 reset = 1'b1;
        #1 chk("abort_bus_idle", obs, mk(1, 1, 0, 1, 8'hFF, 0, 0));
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        cvld  = '{1'b0, 1'b0};
        bad   = 1'b0;
        repeat (15) begin
          @(negedge clock);
          if (obs.rv || !obs.cs_n) bad = 1'b1;
        end
        chk("abort_no_rsp", bad, 0);
        chk("abort_idle_ready", obs, mk(1, 1, 0, 1, 8'hFF, 0, 1));
        return;
      end
    end
    chk($sformatf("rsp_error a%0d w%0d", a, wr), obs_err, !legal);
    chk($sformatf("rsp_rdata a%0d w%0d", a, wr), obs_rdata, exp_rd);
  endtask

  task automatic random_accesses(input int n);
    bit         wr;
    logic [4:0] a;
    for (int k = 0; k < n; k++) begin
      wr = 1'($urandom);
      if ($urandom_range(0, 3) == 0) a = 5'($urandom);
      else a = wr ? 5'($urandom_range(0, 17)) : 5'($urandom_range(14, 17));
      access(wr, a, 8'($urandom), 8'($urandom), 0);
      idle_cycles($urandom_range(0, 2));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b1;
    sel       = 1'b0;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = 5'd0;
    req_wdata = 8'd0;
    d_in      = 8'd0;
    cvld      = '{1'b0, 1'b0};
    caddr     = '{5'd0, 5'd0};
    repeat (10) @(posedge clock);
    @(negedge clock);
    chk("reset_bus", obs, mk(1, 1, 0, 1, 8'hFF, 0, 0));
    reset = 1'b0;
    repeat (2) @(negedge clock);
    chk("post_reset_bus", obs, mk(1, 1, 0, 1, 8'hFF, 0, 1));
    chk("post_reset_err", obs_err, 0);
    chk("post_reset_rdata", obs_rdata, 0);

    access(1'b1, 5'd0, 8'h55, 8'h00, 0);
    idle_cycles(1);
    access(1'b0, 5'd14, 8'h00, 8'h3C, 0);
    access(1'b0, 5'd15, 8'h00, 8'h12, 0);
    access(1'b0, 5'd16, 8'h00, 8'h34, 0);
    access(1'b0, 5'd17, 8'h00, 8'h56, 0);
    access(1'b1, 5'd18, 8'h01, 8'h00, 0);
    access(1'b0, 5'd5, 8'h00, 8'h77, 0);
    idle_cycles(1);
    random_accesses(40);

    sel = 1'b1;
    idle_cycles(1);
    access(1'b1, 5'd12, 8'hA5, 8'h00, 0);
    random_accesses(12);
    access(1'b1, 5'd12, 8'hA5, 8'h00, 7);

    sel = 1'b0;
    idle_cycles(1);
    access(1'b1, 5'd14, 8'h01, 8'h00, 0);
    access(1'b1, 5'd14, 8'h02, 8'h00, 0);
    access(1'b1, 5'd15, 8'h03, 8'h00, 0);
    random_accesses(20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
